// File: rtl/loadq_mp.sv
// rtl/loadq_mp.sv - multi-port load queue: alloc, pipe arbitration, replay backoff, age-based nuke
// Purpose : holds issued loads, arbitrates READY entries into a single memory pipe and tracks
//           completion / replay.  Entry FSM: IDLE -> READY -> INPIPE -> IDLE, with
//           INPIPE -> WAIT -> READY on replay.
// Optional: define LOADQ_MP_AGE_ARB_EN to arbitrate by oldest robid instead of round-robin.
// Ports   : clk, reset (sync, active-low)
//           nuke_valid/nuke_robid       flush given robid and everything younger
//           alloc_valid/ldqid/robid/pdst/src1/src2   NUM_ALLOC packed alloc ports
//           pipe_req/_ldqid/_robid/_pdst/_vaddr      current arbitration winner
//           pipe_gnt                    pipe accepts the current request
//           rsp_valid/rsp_ldqid/rsp_replay           pipe result (complete or replay)
//           idle/full/num_valid         occupancy of registered state
module loadq_mp #(
    parameter int NUM_ENTRIES  = 8,
    parameter int NUM_ALLOC    = 2,
    parameter int ROBID_W      = 6,
    parameter int PDST_W       = 6,
    parameter int VA_W         = 32,
    parameter int REPLAY_DELAY = 4,
    localparam int LDQ_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         nuke_valid,
    input  logic [ROBID_W-1:0]           nuke_robid,
    input  logic [NUM_ALLOC-1:0]         alloc_valid,
    input  logic [NUM_ALLOC*LDQ_W-1:0]   alloc_ldqid,
    input  logic [NUM_ALLOC*ROBID_W-1:0] alloc_robid,
    input  logic [NUM_ALLOC*PDST_W-1:0]  alloc_pdst,
    input  logic [NUM_ALLOC*VA_W-1:0]    alloc_src1,
    input  logic [NUM_ALLOC*VA_W-1:0]    alloc_src2,
    output logic                         pipe_req,
    output logic [LDQ_W-1:0]             pipe_req_ldqid,
    output logic [ROBID_W-1:0]           pipe_req_robid,
    output logic [PDST_W-1:0]            pipe_req_pdst,
    output logic [VA_W-1:0]              pipe_req_vaddr,
    input  logic                         pipe_gnt,
    input  logic                         rsp_valid,
    input  logic [LDQ_W-1:0]             rsp_ldqid,
    input  logic                         rsp_replay,
    output logic                         idle,
    output logic                         full,
    output logic [LDQ_W:0]               num_valid
);

    localparam int CNT_W = (REPLAY_DELAY > 1) ? $clog2(REPLAY_DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((REPLAY_DELAY > 0) ? REPLAY_DELAY - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_READY, S_INPIPE, S_WAIT} state_e;

    state_e             state_q [NUM_ENTRIES];
    state_e             state_d [NUM_ENTRIES];
    logic [CNT_W-1:0]   cnt_q   [NUM_ENTRIES];
    logic [CNT_W-1:0]   cnt_d   [NUM_ENTRIES];
    logic [ROBID_W-1:0] robid_q [NUM_ENTRIES];
    logic [ROBID_W-1:0] robid_d [NUM_ENTRIES];
    logic [PDST_W-1:0]  pdst_q  [NUM_ENTRIES];
    logic [PDST_W-1:0]  pdst_d  [NUM_ENTRIES];
    logic [VA_W-1:0]    vaddr_q [NUM_ENTRIES];
    logic [VA_W-1:0]    vaddr_d [NUM_ENTRIES];

    logic               arb_valid;
    logic [LDQ_W-1:0]   arb_idx;

    // Wrap-aware: e is the same age as or younger than n when (e - n) has a clear MSB.
    function automatic logic is_flushed(input logic [ROBID_W-1:0] e, input logic [ROBID_W-1:0] n);
        logic [ROBID_W-1:0] diff;
        diff = e - n;
        return ~diff[ROBID_W-1];
    endfunction

`ifdef LOADQ_MP_AGE_ARB_EN
    // Oldest READY robid wins; strict compare keeps the lowest ldqid on ties.
    always_comb begin
        logic [ROBID_W-1:0] best_robid;
        best_robid = '0;
        arb_valid  = 1'b0;
        arb_idx    = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (state_q[i] == S_READY && (!arb_valid || !is_flushed(robid_q[i], best_robid))) begin
                arb_valid  = 1'b1;
                arb_idx    = LDQ_W'(i);
                best_robid = robid_q[i];
            end
        end
    end
`else
    logic [LDQ_W-1:0] rr_q;
    logic [LDQ_W-1:0] rr_d;

    always_comb begin
        logic [LDQ_W-1:0] idx;
        idx       = '0;
        arb_valid = 1'b0;
        arb_idx   = '0;
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            idx = LDQ_W'((int'(rr_q) + k) % NUM_ENTRIES);
            if (!arb_valid && state_q[idx] == S_READY) begin
                arb_valid = 1'b1;
                arb_idx   = idx;
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (pipe_gnt && arb_valid) begin
            rr_d = (arb_idx == LDQ_W'(NUM_ENTRIES - 1)) ? '0 : arb_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) rr_q <= '0;
        else        rr_q <= rr_d;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!reset) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
                robid_q[i] <= '0;
                pdst_q[i]  <= '0;
                vaddr_q[i] <= '0;
            end else begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                robid_q[i] <= robid_d[i];
                pdst_q[i]  <= pdst_d[i];
                vaddr_q[i] <= vaddr_d[i];
            end
        end
    end

    // Next-state: normal transitions, then nuke overrides them, then allocs land on top.
    always_comb begin
        logic [LDQ_W-1:0]   a_idx;
        logic [ROBID_W-1:0] a_robid;
        a_idx   = '0;
        a_robid = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            robid_d[i] = robid_q[i];
            pdst_d[i]  = pdst_q[i];
            vaddr_d[i] = vaddr_q[i];
            case (state_q[i])
                S_READY: begin
                    if (pipe_gnt && arb_valid && arb_idx == LDQ_W'(i)) state_d[i] = S_INPIPE;
                end
                S_INPIPE: begin
                    if (rsp_valid && rsp_ldqid == LDQ_W'(i)) begin
                        if (!rsp_replay) begin
                            state_d[i] = S_IDLE;
                        end else if (REPLAY_DELAY == 0) begin
                            state_d[i] = S_READY;
                        end else begin
                            state_d[i] = S_WAIT;
                            cnt_d[i]   = CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q[i] == '0) state_d[i] = S_READY;
                    else                cnt_d[i]   = cnt_q[i] - 1'b1;
                end
                default: ;
            endcase
            if (nuke_valid && is_flushed(robid_q[i], nuke_robid)) state_d[i] = S_IDLE;
        end
        // Ascending port order: a later port targeting the same entry overwrites an earlier one.
        for (int p = 0; p < NUM_ALLOC; p++) begin
            a_idx   = alloc_ldqid[p*LDQ_W +: LDQ_W];
            a_robid = alloc_robid[p*ROBID_W +: ROBID_W];
            if (alloc_valid[p] && !(nuke_valid && is_flushed(a_robid, nuke_robid))) begin
                state_d[a_idx] = S_READY;
                cnt_d[a_idx]   = '0;
                robid_d[a_idx] = a_robid;
                pdst_d[a_idx]  = alloc_pdst[p*PDST_W +: PDST_W];
                vaddr_d[a_idx] = alloc_src1[p*VA_W +: VA_W] + alloc_src2[p*VA_W +: VA_W];
            end
        end
    end

    // Outputs
    always_comb begin
        num_valid = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (state_q[i] != S_IDLE) num_valid = num_valid + 1'b1;
        end
        idle           = (num_valid == '0);
        full           = (num_valid == (LDQ_W+1)'(NUM_ENTRIES));
        pipe_req       = arb_valid;
        pipe_req_ldqid = arb_valid ? arb_idx          : '0;
        pipe_req_robid = arb_valid ? robid_q[arb_idx] : '0;
        pipe_req_pdst  = arb_valid ? pdst_q[arb_idx]  : '0;
        pipe_req_vaddr = arb_valid ? vaddr_q[arb_idx] : '0;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < NUM_ALLOC; p++) begin
                if (alloc_valid[p]) begin
                    assert (state_q[alloc_ldqid[p*LDQ_W +: LDQ_W]] == S_IDLE)
                        else $error("loadq_mp: alloc to busy entry on port %0d", p);
                    for (int r = p + 1; r < NUM_ALLOC; r++) begin
                        assert (!(alloc_valid[r] && alloc_ldqid[r*LDQ_W +: LDQ_W] == alloc_ldqid[p*LDQ_W +: LDQ_W]))
                            else $error("loadq_mp: ports %0d and %0d alloc the same entry", p, r);
                    end
                end
            end
        end
    end
`endif

endmodule
